// File: rtl/btn_pkg.sv
// Shared state encoding for the push-button debouncer.
// The encodings are chosen so that state_out can drive debug LEDs directly.
package btn_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b11,
        RELEASE_WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// It has an async active-high clear, so it can be reused for the other board inputs.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, then emit a level plus press/release strobes.
// Auto-repeat of press_pulse while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned REPEAT_DELAY  = 20000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    output logic               level,
    output logic               press_pulse,
    output logic               rel_pulse,
    output logic [STATE_W-1:0] state_out
);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("btn_debounce: DB_CYCLES must be at least 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_rpt
        $error("btn_debounce: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
    end

    localparam int unsigned    DB_W    = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            w_s2;
    state_t          r_state;
    state_t          w_state_d;
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_cnt_d;
    logic            w_rpt_fire;
    logic            w_level_d;
    logic            w_press_d;
    logic            w_rel_d;
    logic            r_level;
    logic            r_press;
    logic            r_rel;

    sync_2ff u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (btn_in),
        .o_q   (w_s2)
    );

    // A reverted input takes priority over a terminal count, so a collision never accepts.
    always_comb begin
        w_state_d  = r_state;
        w_db_cnt_d = r_db_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_s2) begin
                    w_state_d  = PRESS_WAIT;
                    w_db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s2) begin
                    w_state_d  = IDLE;
                    w_db_cnt_d = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_d  = PRESSED;
                    w_db_cnt_d = '0;
                end else begin
                    w_db_cnt_d = r_db_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_s2) begin
                    w_state_d  = RELEASE_WAIT;
                    w_db_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_s2) begin
                    w_state_d  = PRESSED;
                    w_db_cnt_d = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_d  = IDLE;
                    w_db_cnt_d = '0;
                end else begin
                    w_db_cnt_d = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d  = IDLE;
                w_db_cnt_d = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned     RPT_W      = $clog2(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_d;

    // Reloading to DELAY-PERIOD makes later strobes land every REPEAT_PERIOD cycles.
    // The count is held in RELEASE_WAIT and restarts on any entry to PRESSED.
    always_comb begin
        w_rpt_cnt_d = r_rpt_cnt;
        w_rpt_fire  = 1'b0;
        if (w_state_d == PRESSED && r_state != PRESSED) begin
            w_rpt_cnt_d = '0;
        end else if (r_state == PRESSED && w_state_d == PRESSED) begin
            if (r_rpt_cnt == RPT_LAST) begin
                w_rpt_fire  = 1'b1;
                w_rpt_cnt_d = RPT_RELOAD;
            end else begin
                w_rpt_cnt_d = r_rpt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpt_cnt <= '0;
        end else begin
            r_rpt_cnt <= w_rpt_cnt_d;
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_comb begin
        w_level_d = (w_state_d == PRESSED) || (w_state_d == RELEASE_WAIT);
        w_press_d = ((r_state == PRESS_WAIT) && (w_state_d == PRESSED)) || w_rpt_fire;
        w_rel_d   = (r_state == RELEASE_WAIT) && (w_state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
            r_press  <= 1'b0;
            r_rel    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_db_cnt <= w_db_cnt_d;
            r_level  <= w_level_d;
            r_press  <= w_press_d;
            r_rel    <= w_rel_d;
        end
    end

    assign level       = r_level;
    assign press_pulse = r_press;
    assign rel_pulse   = r_rel;
    assign state_out   = r_state;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_btn_debounce;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned RP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       level;
    logic       press_pulse;
    logic       rel_pulse;
    logic [1:0] state_out;

    always #5 clk = ~clk;

    btn_debounce #(
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .level       (level),
        .press_pulse (press_pulse),
        .rel_pulse   (rel_pulse),
        .state_out   (state_out)
    );

    typedef struct packed {
        logic       btn;
        logic [1:0] st;
        logic       lvl;
        logic       pp;
        logic       rp;
    } vec_t;

    vec_t  vecs[$];
    string tags[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    task automatic add(input string tag, input logic b, input logic [1:0] s,
                       input logic l, input logic p, input logic r);
        vec_t v;
        v.btn = b;
        v.st  = s;
        v.lvl = l;
        v.pp  = p;
        v.rp  = r;
        vecs.push_back(v);
        tags.push_back(tag);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] obs();
        return {state_out, level, press_pulse, rel_pulse};
    endfunction

    localparam logic [10:0] REL_BTN = 11'b00100000000;
    localparam logic [21:0] REL_ST  = 22'b11_11_10_10_11_10_10_10_10_00_00;

    initial begin
        int first;
        int n_press;
        int n_rel;
        int n_overlap;
        int got_rpt[$];
        int exp_rpt[$];
        logic [10:0] rel_btn;
        logic [21:0] rel_st;

        rel_btn = REL_BTN;
        rel_st  = REL_ST;

        // Clean press then clean release, starting from IDLE with flops clear.
        for (int i = 0; i < 9; i++)
            add("clean_press", 1'b1, (i < 2) ? 2'b00 : (i < 6) ? 2'b01 : 2'b11,
                i >= 6, i == 6, 1'b0);
        for (int j = 0; j < 8; j++)
            add("clean_release", 1'b0, (j < 2) ? 2'b11 : (j < 6) ? 2'b10 : 2'b00,
                j < 6, 1'b0, j == 6);
        // Three-cycle bursts never survive debounce.
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 6; k++)
                add("bounce", k < 3, (k >= 2 && k <= 4) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0);
        // Input falls exactly when the counter reaches its terminal value.
        for (int k = 0; k < 8; k++)
            add("collision", k < 4, (k >= 2 && k <= 5) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0);
        // Press, then release with one bounce back to PRESSED.
        for (int k = 0; k < 7; k++)
            add("press2", 1'b1, (k < 2) ? 2'b00 : (k < 6) ? 2'b01 : 2'b11,
                k == 6, k == 6, 1'b0);
        for (int k = 0; k < 11; k++)
            add("rel_bounce", rel_btn[10-k], rel_st[21-2*k -: 2], k < 9, 1'b0, k == 9);

        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].btn);
            check($sformatf("vec%0d_%s", i, tags[i]), 32'(obs()),
                  32'({vecs[i].st, vecs[i].lvl, vecs[i].pp, vecs[i].rp}));
        end

        // Async reset while in PRESS_WAIT with db_cnt=2.
        repeat (5) step(1'b1);
        check("pw_before_rst", 32'(state_out), 32'(2'b01));
        #2 rst = 1'b1;
        #1 check("async_rst_in_pw", 32'(obs()), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        first = -1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (press_pulse && first < 0) first = e;
        end
        check("rst_exit_press_edge", 32'(first), 32'd6);
        check("pressed_after_rst_exit", 32'(obs()), 32'(5'b11100));

        // Async reset from PRESSED drops level at once and emits nothing afterwards.
        #2 rst = 1'b1;
        #1 check("async_rst_in_pressed", 32'(obs()), 32'd0);
        @(negedge clk);
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        n_press = 0;
        n_rel   = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            n_press += int'(press_pulse);
            n_rel   += int'(rel_pulse);
        end
        check("no_strobe_after_rst", 32'(n_press + n_rel), 32'd0);

        // Long hold: one press strobe, plus repeats when auto-repeat is built in.
        n_overlap = 0;
        for (int e = 0; e < 30; e++) begin
            step(1'b1);
            if (press_pulse) got_rpt.push_back(e);
            if (press_pulse && rel_pulse) n_overlap++;
        end
`ifdef BTN_AUTOREPEAT_EN
        exp_rpt = '{6, 14, 17, 20, 23, 26, 29};
`else
        exp_rpt = '{6};
`endif
        check("hold_press_count", 32'(got_rpt.size()), 32'(exp_rpt.size()));
        for (int i = 0; i < exp_rpt.size() && i < got_rpt.size(); i++)
            check($sformatf("hold_press_edge%0d", i), 32'(got_rpt[i]), 32'(exp_rpt[i]));
        check("hold_level", 32'(level), 32'd1);

        n_press = 0;
        n_rel   = 0;
        for (int e = 0; e < 12; e++) begin
            step(1'b0);
            n_press += int'(press_pulse);
            n_rel   += int'(rel_pulse);
            if (press_pulse && rel_pulse) n_overlap++;
        end
        check("hold_release_rel_count", 32'(n_rel), 32'd1);
        check("hold_release_no_press", 32'(n_press), 32'd0);
        check("strobe_overlap", 32'(n_overlap), 32'd0);
        check("final_idle", 32'(obs()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the FSM's `count` request input.
- Takes a raw, asynchronous, bouncing push-button signal and synchronises it into clk.
- Qualifies it with a consecutive-sample debounce counter.
- Delivers a clean level plus single-cycle press/release strobes; press_pulse drives the downstream FSM's count input directly.

Parameters:
- DB_CYCLES, 1000000: consecutive stable synchronised samples required to accept a level change; legal range ≥ 2.
- REPEAT_DELAY, 20000000: hold time in cycles before the first auto-repeat strobe (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat strobes (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- btn_in  in  1  raw button, asynchronous to clk, active-high.
- level  out  1  debounced button level.
- press_pulse  out  1  one-cycle strobe on accepted press (and on auto-repeat).
- rel_pulse  out  1  one-cycle strobe on accepted release.
- state_out  out  2  current FSM state, for debug/LEDs.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All registers clear immediately on rst=1, independent of clk.
- Reset values: level=0, press_pulse=0, rel_pulse=0, state_out=IDLE, sync flops=0, counters=0.
- Synchroniser: two flops, s1 <= btn_in, s2 <= s1. Only s2 is used by the FSM.
- FSM states and encodings: IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b11, RELEASE_WAIT=2'b10.
- IDLE: s2=1 -> PRESS_WAIT, db_cnt <= 0.
- PRESS_WAIT: s2=0 -> IDLE with db_cnt cleared (bounce rejected). s2=1 and db_cnt==DB_CYCLES-1 -> PRESSED. Otherwise db_cnt++.
- PRESSED: s2=0 -> RELEASE_WAIT, db_cnt <= 0.
- RELEASE_WAIT: s2=1 -> PRESSED with db_cnt cleared. s2=0 and db_cnt==DB_CYCLES-1 -> IDLE. Otherwise db_cnt++.
- Simultaneous terminal count and input reversion: reversion wins; no transition to the new stable state and no strobe.
- Outputs are registered:
  - level=1 exactly while in PRESSED or RELEASE_WAIT.
  - press_pulse is set on the edge entering PRESSED from PRESS_WAIT, high for exactly one cycle.
  - rel_pulse is set on the edge entering IDLE from RELEASE_WAIT.
  - PRESSED<->RELEASE_WAIT bounces produce no strobes.
- Latency: counting the edge that first samples btn_in=1 as edge 0, level and press_pulse go high after edge DB_CYCLES+2. Release latency is symmetric.
- Widths: db_cnt is $clog2(DB_CYCLES) bits. The counter never wraps; it is cleared on every state change.
- A pulse shorter than DB_CYCLES synchronised samples never reaches the outputs.
- Reset mid-operation (any state): outputs drop to 0 immediately. No strobe is emitted on reset entry or exit.
- press_pulse and rel_pulse are never high in the same cycle.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - rpt_cnt ($clog2(REPEAT_DELAY) bits) clears on entry to PRESSED and counts while in PRESSED.
  - At REPEAT_DELAY-1 it emits press_pulse and reloads for REPEAT_PERIOD. Thereafter press_pulse fires every REPEAT_PERIOD cycles.
  - rpt_cnt is frozen in RELEASE_WAIT and cleared on return to PRESSED from RELEASE_WAIT.
  - A repeat strobe is never emitted on the cycle of the initial press strobe.
- Undefined: no rpt_cnt logic exists; exactly one press_pulse per accepted press.

Decomposition:
- Package btn_pkg: state localparams (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the 2-bit state width.
- Sub-module sync_2ff: a 1-bit, two-flop synchroniser with async active-high clear, reusable for the other board inputs.
- FSM and counters stay in btn_debounce.

Test Plan (DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Clean press: btn_in 0->1 before edge 0, held -> press_pulse=1 for exactly one cycle after edge 6; level=1 from edge 6; state_out sequence 00,01,11.
- Bounce reject: btn_in high for 3 cycles then low, repeated 5 times -> press_pulse never 1, level stays 0, state_out returns to 00 each time.
- Release with bounce: from PRESSED, btn_in low 2 cycles, high 1 cycle, low steady -> exactly one rel_pulse, 4+2 edges after the final low is first sampled; level=0 afterwards; no extra press_pulse.
- Async reset mid-wait: rst=1 between edges while in PRESS_WAIT with db_cnt=2 -> all outputs 0 before next edge. After rst=0 with btn_in held high, press_pulse comes 7 edges later.
- Auto-repeat (BTN_AUTOREPEAT_EN defined): hold btn_in 30 cycles -> press_pulse at accept edge, then 8 cycles later, then every 3 cycles. Undefined macro: single press_pulse only.
- Terminal-count collision: s2 drops on the same edge db_cnt==3 in PRESS_WAIT -> state returns to IDLE, no press_pulse.
